// File: rtl/mem_access.sv
// Memory-access pipeline stage: single-outstanding req/ack data bus, store lane
// replication, load alignment/extension and registered MEM/WB results.
module mem_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic        mem_inst_valid,
    input  logic [31:0] mem_inst_pc,
    input  logic [3:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    input  logic        flush,
    input  logic        dack,
    input  logic [31:0] drdata,
    output logic        dreq,
    output logic [3:0]  dwe,
    output logic [31:0] daddr,
    output logic [31:0] dwdata,
    output logic        stall_req,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        wb_inst_valid,
    output logic [31:0] wb_inst_pc,
    output logic        wb_ale
);

    localparam logic [3:0] OP_LD_B  = 4'd1;
    localparam logic [3:0] OP_LD_H  = 4'd2;
    localparam logic [3:0] OP_LD_W  = 4'd3;
    localparam logic [3:0] OP_LD_BU = 4'd4;
    localparam logic [3:0] OP_LD_HU = 4'd5;
    localparam logic [3:0] OP_ST_B  = 4'd6;
    localparam logic [3:0] OP_ST_H  = 4'd7;
    localparam logic [3:0] OP_ST_W  = 4'd8;

    typedef enum logic { IDLE, BUSY } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  op_reg;
    logic [1:0]  off_reg;
    logic [4:0]  wd_reg;
    logic        wreg_reg;
    logic [31:0] pc_reg;
    logic        drop_reg;

    logic        is_load, is_store, is_mem, misaligned, issue;
    logic [3:0]  st_dwe;
    logic [31:0] st_wdata;
    logic [31:0] rd_shift;
    logic [31:0] load_data;

    always_comb begin
        is_load    = (mem_op >= OP_LD_B) && (mem_op <= OP_LD_HU);
        is_store   = (mem_op >= OP_ST_B) && (mem_op <= OP_ST_W);
        is_mem     = is_load || is_store;
        misaligned = ((mem_op == OP_LD_H || mem_op == OP_LD_HU || mem_op == OP_ST_H) && mem_addr[0])
                  || ((mem_op == OP_LD_W || mem_op == OP_ST_W) && (mem_addr[1:0] != 2'b00));
        issue      = (state_reg == IDLE) && mem_inst_valid && is_mem && !misaligned && !flush;
        stall_req  = issue || ((state_reg == BUSY) && !dack);
    end

    always_comb begin
        st_dwe   = 4'b0000;
        st_wdata = 32'd0;
        case (mem_op)
            OP_ST_B: begin
                st_dwe   = 4'b0001 << mem_addr[1:0];
                st_wdata = {4{mem_sdata[7:0]}};
            end
            OP_ST_H: begin
                st_dwe   = 4'b0011 << mem_addr[1:0];
                st_wdata = {2{mem_sdata[15:0]}};
            end
            OP_ST_W: begin
                st_dwe   = 4'b1111;
                st_wdata = mem_sdata;
            end
            default: ;
        endcase
    end

    // Byte/halfword lanes are brought down to bit 0 using the latched offset.
    always_comb begin
        rd_shift  = drdata >> {off_reg, 3'b000};
        load_data = 32'd0;
        case (op_reg)
            OP_LD_B:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            OP_LD_BU: load_data = {24'd0, rd_shift[7:0]};
            OP_LD_H:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            OP_LD_HU: load_data = {16'd0, rd_shift[15:0]};
            OP_LD_W:  load_data = drdata;
            default:  load_data = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (issue) state_next = BUSY;
            BUSY:    if (dack)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dreq          <= 1'b0;
            dwe           <= 4'b0000;
            daddr         <= 32'd0;
            dwdata        <= 32'd0;
            op_reg        <= 4'd0;
            off_reg       <= 2'd0;
            wd_reg        <= 5'd0;
            wreg_reg      <= 1'b0;
            pc_reg        <= 32'd0;
            drop_reg      <= 1'b0;
            wb_wd         <= 5'd0;
            wb_wreg       <= 1'b0;
            wb_wdata      <= 32'd0;
            wb_inst_valid <= 1'b0;
            wb_inst_pc    <= 32'd0;
            wb_ale        <= 1'b0;
        end else begin
            wb_inst_valid <= 1'b0;
            wb_wreg       <= 1'b0;
            wb_ale        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        op_reg   <= mem_op;
                        off_reg  <= mem_addr[1:0];
                        wd_reg   <= mem_wd;
                        wreg_reg <= mem_wreg && is_load;
                        pc_reg   <= mem_inst_pc;
                        drop_reg <= 1'b0;
                        dreq     <= 1'b1;
                        daddr    <= {mem_addr[31:2], 2'b00};
                        dwe      <= st_dwe;
                        dwdata   <= st_wdata;
                    end else if (mem_inst_valid && !flush) begin
                        // Misaligned memory ops retire immediately as exceptions.
                        wb_wd         <= mem_wd;
                        wb_wdata      <= mem_wdata;
                        wb_inst_pc    <= mem_inst_pc;
                        wb_inst_valid <= 1'b1;
                        wb_wreg       <= is_mem ? 1'b0 : mem_wreg;
                        wb_ale        <= is_mem;
                    end
                end
                BUSY: begin
                    if (dack) begin
                        dreq     <= 1'b0;
                        dwe      <= 4'b0000;
                        drop_reg <= 1'b0;
                        if (!drop_reg && !flush) begin
                            wb_wd         <= wd_reg;
                            wb_wreg       <= wreg_reg;
                            wb_wdata      <= load_data;
                            wb_inst_pc    <= pc_reg;
                            wb_inst_valid <= 1'b1;
                        end
                    end else if (flush) begin
                        drop_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected MEM/WB results,
// a negedge monitor pops and compares whenever wb_inst_valid is high.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_inst_valid;
    logic [31:0] mem_inst_pc;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        flush;
    logic        dack;
    logic [31:0] drdata;
    logic        dreq;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        stall_req;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_inst_valid;
    logic [31:0] wb_inst_pc;
    logic        wb_ale;

    mem_access dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_inst_valid(mem_inst_valid), .mem_inst_pc(mem_inst_pc),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .flush(flush), .dack(dack), .drdata(drdata),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .stall_req(stall_req),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .wb_inst_valid(wb_inst_valid), .wb_inst_pc(wb_inst_pc), .wb_ale(wb_ale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic        ale;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                        input logic [31:0] pc, input logic ale);
        exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.pc = pc; e.ale = ale;
        exp_q.push_back(e);
    endtask

    // wb_wdata is only meaningful when a register write is expected.
    always @(negedge clk) begin
        if (wb_inst_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got pc=0x%08h wd=%0d, expected no output", wb_inst_pc, wb_wd);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wb_wd !== e.wd || wb_wreg !== e.wreg || wb_inst_pc !== e.pc || wb_ale !== e.ale
                    || (e.wreg && wb_wdata !== e.wdata)) begin
                    errors++;
                    $display("FAIL wb_result: got wd=%0d wreg=%0b wdata=0x%08h pc=0x%08h ale=%0b, expected wd=%0d wreg=%0b wdata=0x%08h pc=0x%08h ale=%0b",
                             wb_wd, wb_wreg, wb_wdata, wb_inst_pc, wb_ale, e.wd, e.wreg, e.wdata, e.pc, e.ale);
                end else begin
                    $display("txn pc=0x%08h wd=%0d wreg=%0b wdata=0x%08h ale=%0b ok",
                             wb_inst_pc, wb_wd, wb_wreg, wb_wdata, wb_ale);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_inst_valid = 1'b0;
        mem_op         = 4'd0;
        mem_wreg       = 1'b0;
        flush          = 1'b0;
        dack           = 1'b0;
        drdata         = 32'hDEAD_BEEF;
    endtask

    task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [4:0] wd, input logic wr, input logic [31:0] wdata,
                           input logic [31:0] pc);
        mem_inst_valid = 1'b1;
        mem_op         = op;
        mem_addr       = addr;
        mem_sdata      = sdata;
        mem_wd         = wd;
        mem_wreg       = wr;
        mem_wdata      = wdata;
        mem_inst_pc    = pc;
    endtask

    // One bus transaction; flush_cyc selects a wait cycle to flush in (-1: none).
    task automatic mem_txn(input string name, input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata, input logic [4:0] wd,
                           input logic [31:0] pc, input int waits, input int flush_cyc,
                           input logic [3:0] exp_dwe, input logic [31:0] exp_dwdata,
                           input logic [31:0] exp_wdata, input logic exp_wreg);
        int stalls;
        stalls = 0;
        present(op, addr, sdata, wd, 1'b1, 32'h5555_5555, pc);
        #1;
        if (stall_req === 1'b1) stalls++;
        step();
        for (int i = 0; i < waits; i++) begin
            if (stall_req === 1'b1) stalls++;
            flush = (i == flush_cyc);
            #1;
            step();
            flush = 1'b0;
        end
        chk({name, "_dreq"}, {31'd0, dreq}, 32'd1);
        chk({name, "_daddr"}, daddr, {addr[31:2], 2'b00});
        chk({name, "_dwe"}, {28'd0, dwe}, {28'd0, exp_dwe});
        if (exp_dwe != 4'b0000) chk({name, "_dwdata"}, dwdata, exp_dwdata);
        dack   = 1'b1;
        drdata = rdata;
        #1;
        chk({name, "_ack_stall"}, {31'd0, stall_req}, 32'd0);
        chk({name, "_stall_cycles"}, stalls, waits + 1);
        if (flush_cyc < 0) push(wd, exp_wreg, exp_wdata, pc, 1'b0);
        step();
        idle_inputs();
        chk({name, "_dreq_done"}, {31'd0, dreq}, 32'd0);
        chk({name, "_wb_valid"}, {31'd0, wb_inst_valid}, (flush_cyc < 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        mem_wd    = 5'd0;
        mem_wdata = 32'd0;
        mem_inst_pc = 32'd0;
        mem_addr  = 32'd0;
        mem_sdata = 32'd0;
        idle_inputs();
        repeat (3) step();
        chk("rst_dreq", {31'd0, dreq}, 32'd0);
        chk("rst_dwe", {28'd0, dwe}, 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_dwdata", dwdata, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_inst_valid}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_wb_ale", {31'd0, wb_ale}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        rst = 1'b1;
        step();

        // ALU op passes through in one cycle
        present(4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 32'h100);
        push(5'd3, 1'b1, 32'h1234, 32'h100, 1'b0);
        step();
        idle_inputs();
        chk("alu_dreq", {31'd0, dreq}, 32'd0);
        chk("alu_wb_wdata", wb_wdata, 32'h1234);

        // Loads, back to back
        mem_txn("ldb",  4'd1, 32'h1003, 32'h0, 32'h80FF_0000, 5'd5, 32'h104, 3, -1, 4'b0000, 32'h0, 32'hFFFF_FF80, 1'b1);
        mem_txn("ldbu", 4'd4, 32'h1003, 32'h0, 32'h80FF_0000, 5'd6, 32'h108, 3, -1, 4'b0000, 32'h0, 32'h0000_0080, 1'b1);
        mem_txn("ldh",  4'd2, 32'h1002, 32'h0, 32'h80FF_0000, 5'd7, 32'h10C, 0, -1, 4'b0000, 32'h0, 32'hFFFF_80FF, 1'b1);
        mem_txn("ldhu", 4'd5, 32'h1000, 32'h0, 32'h1234_F00D, 5'd8, 32'h110, 1, -1, 4'b0000, 32'h0, 32'h0000_F00D, 1'b1);
        mem_txn("ldw",  4'd3, 32'h1004, 32'h0, 32'hCAFE_BABE, 5'd9, 32'h114, 2, -1, 4'b0000, 32'h0, 32'hCAFE_BABE, 1'b1);

        // Stores: strobes, lane replication, no register write
        mem_txn("sth", 4'd7, 32'h2002, 32'h0000_ABCD, 32'h0, 5'd10, 32'h118, 1, -1, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0);
        mem_txn("stb", 4'd6, 32'h4001, 32'h1234_5678, 32'h0, 5'd11, 32'h11C, 0, -1, 4'b0010, 32'h7878_7878, 32'h0, 1'b0);
        mem_txn("stw", 4'd8, 32'h5000, 32'h89AB_CDEF, 32'h0, 5'd12, 32'h120, 2, -1, 4'b1111, 32'h89AB_CDEF, 32'h0, 1'b0);

        // Misaligned accesses raise wb_ale without a bus request
        present(4'd3, 32'h3001, 32'h0, 5'd13, 1'b1, 32'h0, 32'h124);
        #1;
        chk("ale_ldw_stall", {31'd0, stall_req}, 32'd0);
        push(5'd13, 1'b0, 32'h0, 32'h124, 1'b1);
        step();
        present(4'd7, 32'h2001, 32'h0, 5'd14, 1'b1, 32'h0, 32'h128);
        #1;
        chk("ale_ldw_dreq", {31'd0, dreq}, 32'd0);
        push(5'd14, 1'b0, 32'h0, 32'h128, 1'b1);
        step();
        idle_inputs();
        chk("ale_sth_dreq", {31'd0, dreq}, 32'd0);

        // Flush in IDLE: bubble, no request
        present(4'd3, 32'h6000, 32'h0, 5'd15, 1'b1, 32'h0, 32'h12C);
        flush = 1'b1;
        #1;
        chk("flush_idle_stall", {31'd0, stall_req}, 32'd0);
        step();
        idle_inputs();
        chk("flush_idle_dreq", {31'd0, dreq}, 32'd0);

        // Flush in first BUSY cycle: transaction completes, result dropped
        mem_txn("flushbusy", 4'd3, 32'h7000, 32'h0, 32'h1111_2222, 5'd16, 32'h130, 2, 0, 4'b0000, 32'h0, 32'h0, 1'b1);

        // Reset while BUSY
        present(4'd8, 32'h8000, 32'hFFFF_0000, 5'd17, 1'b0, 32'h0, 32'h134);
        step();
        step();
        chk("rstbusy_dreq_before", {31'd0, dreq}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstbusy_dreq", {31'd0, dreq}, 32'd0);
        chk("rstbusy_dwe", {28'd0, dwe}, 32'd0);
        chk("rstbusy_daddr", daddr, 32'd0);
        chk("rstbusy_wb_pc", wb_inst_pc, 32'd0);
        idle_inputs();
        step();
        rst = 1'b1;
        step();
        present(4'd0, 32'h0, 32'h0, 5'd20, 1'b1, 32'h0BAD_F00D, 32'h200);
        push(5'd20, 1'b1, 32'h0BAD_F00D, 32'h200, 1'b0);
        step();
        idle_inputs();
        chk("post_rst_dreq", {31'd0, dreq}, 32'd0);

        repeat (4) step();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
